// File: rtl/score_display_ctrl.sv
// Foosball scoreboard digit sequencer: lamp test, BCD conversion by repeated subtract, post-update blink.
// Optional macro SCORE_LEADZERO_BLANK_EN blanks a zero tens digit outside the lamp test and dark blink halves.
module score_display_ctrl #(
  parameter int LAMP_CYCLES   = 50_000_000,
  parameter int BLINK_HALF    = 12_500_000,
  parameter int BLINK_TOGGLES = 6
) (
  input  logic       i_clk,
  input  logic       i_resetN,
  input  logic [6:0] i_scoreA,
  input  logic [6:0] i_scoreB,
  input  logic       i_update,
  output logic       o_busy,
  output logic [3:0] o_hex0,
  output logic [3:0] o_hex1,
  output logic [3:0] o_hex2,
  output logic [3:0] o_hex3,
  output logic [3:0] o_darkN,
  output logic       o_lampTest
);

  localparam int CMAX = (LAMP_CYCLES > BLINK_HALF) ? LAMP_CYCLES : BLINK_HALF;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int HW   = $clog2(BLINK_TOGGLES + 1);

  typedef enum logic [2:0] {
    S_LAMP, S_IDLE, S_CONV_A, S_CONV_B, S_COMMIT, S_BLINK
  } state_t;

  state_t              r_state, w_next;
  logic [CW-1:0]       r_cnt;
  logic [HW-1:0]       r_half;
  logic                r_pend;
  logic [6:0]          r_workA, r_workB;
  logic [3:0]          r_tensA, r_unitsA, r_tensB, r_unitsB;
  logic [3:0][3:0]     r_hex;

  logic                w_lamp_done, w_half_end, w_blink_done, w_start, w_run;
  logic [6:0]          w_satA, w_satB;
  logic [3:0]          w_lit;

  assign w_satA       = (i_scoreA > 7'd99) ? 7'd99 : i_scoreA;
  assign w_satB       = (i_scoreB > 7'd99) ? 7'd99 : i_scoreB;
  assign w_lamp_done  = (r_cnt == CW'(LAMP_CYCLES - 1));
  assign w_half_end   = (r_cnt == CW'(BLINK_HALF - 1));
  assign w_blink_done = w_half_end && (r_half == HW'(BLINK_TOGGLES - 1));
  assign w_start      = (r_state == S_IDLE) && (i_update || r_pend);
  // Strobes are only pended while a conversion/blink run is in flight, never during lamp test.
  assign w_run        = (r_state != S_IDLE) && (r_state != S_LAMP);

  always_ff @(posedge i_clk or negedge i_resetN) begin
    if (!i_resetN) r_state <= S_LAMP;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LAMP:   if (w_lamp_done) w_next = S_IDLE;
      S_IDLE:   if (w_start) w_next = S_CONV_A;
      S_CONV_A: if (r_workA < 7'd10) w_next = S_CONV_B;
      S_CONV_B: if (r_workB < 7'd10) w_next = S_COMMIT;
      S_COMMIT: w_next = S_BLINK;
      S_BLINK:  if (w_blink_done) w_next = S_IDLE;
      default:  w_next = S_LAMP;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resetN) begin
    if (!i_resetN) begin
      r_cnt    <= '0;
      r_half   <= '0;
      r_pend   <= 1'b0;
      r_workA  <= '0;
      r_workB  <= '0;
      r_tensA  <= '0;
      r_unitsA <= '0;
      r_tensB  <= '0;
      r_unitsB <= '0;
      r_hex    <= '0;
    end else begin
      case (r_state)
        S_LAMP: r_cnt <= w_lamp_done ? '0 : r_cnt + CW'(1);
        S_IDLE: if (w_start) begin
          r_workA <= w_satA;
          r_workB <= w_satB;
          r_tensA <= '0;
          r_tensB <= '0;
          r_pend  <= 1'b0;
        end
        S_CONV_A: if (r_workA >= 7'd10) begin
          r_workA <= r_workA - 7'd10;
          r_tensA <= r_tensA + 4'd1;
        end else r_unitsA <= r_workA[3:0];
        S_CONV_B: if (r_workB >= 7'd10) begin
          r_workB <= r_workB - 7'd10;
          r_tensB <= r_tensB + 4'd1;
        end else r_unitsB <= r_workB[3:0];
        S_COMMIT: begin
          // All four digits swap in one edge so no half-converted score is ever shown.
          r_hex  <= {r_tensB, r_unitsB, r_tensA, r_unitsA};
          r_cnt  <= '0;
          r_half <= '0;
        end
        S_BLINK: if (w_half_end) begin
          r_cnt  <= '0;
          r_half <= r_half + HW'(1);
        end else r_cnt <= r_cnt + CW'(1);
        default: ;
      endcase
      if (i_update && w_run) r_pend <= 1'b1;
    end
  end

`ifdef SCORE_LEADZERO_BLANK_EN
  assign w_lit = {|r_hex[3], 1'b1, |r_hex[1], 1'b1};
`else
  assign w_lit = 4'b1111;
`endif

  assign o_lampTest = (r_state == S_LAMP);
  assign o_busy     = (r_state != S_IDLE);
  assign o_hex0     = r_hex[0];
  assign o_hex1     = r_hex[1];
  assign o_hex2     = r_hex[2];
  assign o_hex3     = r_hex[3];
  // Even-numbered blink halves are dark, so an even toggle count ends lit.
  assign o_darkN    = (r_state == S_LAMP) ? 4'b1111 :
                      ((r_state == S_BLINK) && !r_half[0]) ? 4'b0000 : w_lit;

endmodule

// File: doc/score_display_ctrl.md
Name: score_display_ctrl

Overview:
- Sequences the four seven-segment digits of the foosball scoreboard: digits 1:0 show player A's score and digits 3:2 show player B's score.
- Converts binary scores to BCD using a multi-cycle repeated-subtract-by-10 datapath.
- Runs a power-up lamp test, and blinks the display after each score update.
- Drives four hex-to-7-segment decoder instances through their hex-value, dark-enable (darkN) and lamp-test inputs.

Parameters:
- LAMP_CYCLES, 50_000_000: power-up lamp-test duration in clk cycles (1 s at 50 MHz).
- BLINK_HALF, 12_500_000: clk cycles per blink half-period (dark or lit).
- BLINK_TOGGLES, 6: number of blink half-periods after an update; even value, so the display ends lit.

Ports:
- clk, in, 1: system clock.
- resetN, in, 1: asynchronous active-low reset.
- scoreA, in, 7: player A binary score; values above 99 saturate to 99.
- scoreB, in, 7: player B binary score; same saturation.
- update, in, 1: single-cycle strobe; capture and display the new scores.
- busy, out, 1: high in every state except IDLE.
- hex0, out, 4: A units digit.
- hex1, out, 4: A tens digit.
- hex2, out, 4: B units digit.
- hex3, out, 4: B tens digit.
- darkN, out, 4: per-digit enable to the decoders (bit i drives digit i); 0 = blank.
- lampTest, out, 1: common lamp-test to all decoders.

Behaviour:
- One clock domain, clk. resetN is asynchronous and active-low.
- Reset values:
  - State LAMP, lampTest=1, busy=1.
  - hex0..hex3=0, darkN=4'b1111.
  - Internal cycle counter=0, pending=0.
- State LAMP:
  - lampTest=1; cycle counter counts to LAMP_CYCLES-1.
  - Then lampTest=0 and the state goes to IDLE; displays read 00 00.
- State IDLE:
  - busy=0.
  - When update=1: latch saturated scoreA/scoreB into work registers in that same edge; next state CONV_A.
- State CONV_A:
  - Each cycle: if work>=10, subtract 10 and increment tensA; else unitsA=work and go to CONV_B.
  - Cycles spent = floor(A/10)+1.
- State CONV_B: same algorithm for B; on completion go to COMMIT.
- State COMMIT (1 cycle):
  - hex0..hex3 load the new BCD digits simultaneously.
  - Go to BLINK. Outputs never show partially converted values.
- Latency: update to hex outputs changing = floor(A/10)+floor(B/10)+4 cycles; maximum 22 cycles at 99/99.
- State BLINK:
  - Counter runs BLINK_TOGGLES half-periods of BLINK_HALF cycles each.
  - The first half-period is dark (darkN=0000); halves then alternate.
  - After the last half: darkN restored per the blanking rules, go to IDLE.
- Update arriving while busy (CONV_A, CONV_B, COMMIT, BLINK):
  - Sets pending=1. Multiple strobes collapse into one.
  - Scores are not captured at strobe time.
  - On entering IDLE with pending=1: pending clears, scoreA/scoreB are sampled in that IDLE cycle, and the state goes to CONV_A (a one-cycle IDLE dwell with busy=0).
- Update during LAMP: ignored and not pended.
- Reset asserted mid-operation: immediate return to reset values, including a fresh lamp test.
- Arithmetic: 7-bit work registers; 4-bit tens/units registers. Saturation is applied before conversion: input >=100 is treated as 99.

Optional Feature:
- Macro: SCORE_LEADZERO_BLANK_EN.
- When defined: in every state other than LAMP and the dark BLINK halves:
  - darkN[1]=0 when tensA==0.
  - darkN[3]=0 when tensB==0.
  - Units digits are always lit, so a score of 0 shows a single "0".
- When undefined: tens digits always lit when not blinking, so 7 displays as "07".

Test Plan:
- Reset with LAMP_CYCLES=8, then release -> lampTest=1 for exactly 8 cycles, then 0; hex=0, darkN=1111, busy falls on cycle 9.
- Update with A=37, B=5 (BLINK_HALF=4, BLINK_TOGGLES=6) -> after 3+0+4=7 cycles hex1,hex0=3,7 and hex3,hex2=0,5; darkN 0000/1111 alternating every 4 cycles for 24 cycles; busy low afterwards.
- Update with A=120, B=99 -> displays 99 and 99; latency 22 cycles.
- Update with A=10, B=20, then two more strobes during BLINK with inputs changed to A=11, B=21 -> a single re-conversion after BLINK; final display 11/21; one IDLE cycle with busy=0 between the runs.
- resetN pulsed low during CONV_B -> outputs go to reset values asynchronously; lamp test restarts.
- With SCORE_LEADZERO_BLANK_EN defined, A=4, B=0 -> darkN=0101 after blink; without the macro, darkN=1111.
